tl_traffic_model: RTL and testbench
===================================

// Module: tl_traffic_model
// PURPOSE
//  Intersection traffic model: the sensor side of the traffic-light controller interface.
//  Consumes light codes La/Lb, keeps per-street car queues, and drives occupancy sensors Ta/Tb back to the controller.
//  Closes the loop for self-checking simulation and FPGA demo; sits between the arrival stimulus (buttons/bench) and the controller.
// PARAMETERS
//  QW          4   queue counter width; capacity QMAX = 2**QW-1 cars per street
//  DEPART_CYC  2   clk cycles of continuous green needed for one car to leave (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  reset_n   in   1   asynchronous active-low reset
//  arr_a     in   1   car arrival on street A, one car per cycle sampled high
//  arr_b     in   1   car arrival on street B
//  La        in   2   street A light: 2'b00 green, 2'b01 yellow, 2'b10 red, 2'b11 illegal
//  Lb        in   2   street B light, same encoding
//  Ta        out  1   street A occupied (queue A non-empty)
//  Tb        out  1   street B occupied
//  qa        out  QW  street A queue count
//  qb        out  QW  street B queue count
//  dep_a     out  1   one-cycle pulse: a car left street A
//  dep_b     out  1   one-cycle pulse: a car left street B
//  ovf_a     out  1   sticky: arrival dropped, queue A full
//  ovf_b     out  1   sticky: arrival dropped, queue B full
//  conflict  out  1   sticky: unsafe light combination seen
// BEHAVIOUR
//  Reset (async assert, sync release): qa=qb=0, timers=0; Ta,Tb,dep_*,ovf_*,conflict=0.
//  Per street X, each rising edge:
//   - Crossing timer tX counts 0..DEPART_CYC-1 while LX==green and qX!=0; otherwise tX<=0.
//   - Departure: green && qX!=0 && tX==DEPART_CYC-1 -> dep_X<=1 next cycle, qX decrements, tX<=0.
//   - Yellow/red/illegal: no departure; any partial crossing is discarded (tX<=0).
//   - Arrival with qX<QMAX: qX increments. Arrival with qX==QMAX and no departure: car dropped, ovf_X<=1.
//   - Arrival + departure in the same cycle: qX unchanged, no overflow even when full.
//  Count never wraps: no increment past QMAX, no decrement below 0.
//  Ta = (qa!=0), Tb = (qb!=0), combinational from registered counts.
//   -> Ta rises the cycle after the arriving edge; it falls the cycle after the last departure.
//  dep_X is registered; it is high for exactly one cycle per departed car.
//   -> With DEPART_CYC=1 and a steady green, dep_X stays high on consecutive cycles until qX==0.
//  conflict<=1 when, on any edge, La!=red && Lb!=red, or either code is 2'b11.
//   -> Both yellow counts as a conflict.
//  Sticky flags clear only on reset.
//  Reset mid-crossing: queues empty immediately; no dep pulse is emitted.
//  Streams A and B are independent apart from conflict.
// TESTING
//  1 Reset: hold reset_n=0, toggle arr_a/arr_b, La=Lb=green -> all outputs 0.
//    Release: Ta=Tb=0.
//  2 Arrival: La=Lb=red, arr_a high for 3 cycles.
//    -> qa=1,2,3; Ta=1 from the first edge after; qb=0, Tb=0.
//  3 Departure, DEPART_CYC=2, qa=3, La=green for 6 cycles.
//    -> dep_a on cycles 2, 4, 6; qa=2,1,0; Ta=0 after the third departure.
//    Green for 1 cycle, then yellow -> no departure, qa unchanged.
//  4 Full: QW=4, fill qb=15 under red, one more arr_b -> qb=15, ovf_b=1.
//    Then green with arr_b held high -> qb stays 15 on departure cycles; ovf_b stays 1.
//  5 Conflict: La=green, Lb=yellow for 1 cycle -> conflict=1 and stays 1.
//    Also check La=2'b11 alone -> conflict=1 (fresh reset).
//  6 Reset mid-op: qa=5, green, timer at 1, assert reset_n=0 asynchronously.
//    -> qa=0, Ta=0 immediately; no dep_a after release.

Source files
------------

// File: rtl/tl_traffic_model.sv
// Intersection traffic model: the sensor side of a two-street traffic-light
// controller. It reads the light codes, keeps one car queue per street and
// reports occupancy, departures, overflow and unsafe light combinations.
//
// Light encoding shared by both streets: 2'b00 green, 2'b01 yellow,
// 2'b10 red, 2'b11 illegal.

// One street: car queue counter plus crossing timer.
module tl_traffic_street #(
    parameter int QW         = 4,
    parameter int DEPART_CYC = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_arr,
    input  logic [1:0]    i_light,
    output logic [QW-1:0] o_q,
    output logic          o_dep,
    output logic          o_ovf
);
    // Timer only needs to reach DEPART_CYC-1; keep at least one bit.
    localparam int            TW      = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
    localparam logic [QW-1:0] QMAX    = {QW{1'b1}};
    localparam logic [TW-1:0] T_LAST  = TW'(DEPART_CYC - 1);
    localparam logic [1:0]    L_GREEN = 2'b00;

    logic [QW-1:0] r_q;
    logic [TW-1:0] r_t;
    logic          r_dep;
    logic          r_ovf;

    logic w_green;
    logic w_busy;
    logic w_full;
    logic w_depart;

    assign w_green  = (i_light == L_GREEN);
    assign w_busy   = (r_q != '0);
    assign w_full   = (r_q == QMAX);
    // A car leaves once it has seen DEPART_CYC consecutive green edges.
    assign w_depart = w_green && w_busy && (r_t == T_LAST);

    // Crossing timer: advances on green with a waiting car, otherwise any
    // partial crossing is thrown away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t <= '0;
        end else if (w_green && w_busy && !w_depart) begin
            r_t <= r_t + 1'b1;
        end else begin
            r_t <= '0;
        end
    end

    // Queue count: arrival and departure in the same edge cancel out, which
    // is also why a full queue does not overflow on a departure edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            case ({i_arr, w_depart})
                2'b10: if (!w_full) r_q <= r_q + 1'b1;
                2'b01: r_q <= r_q - 1'b1;
                default: r_q <= r_q;
            endcase
        end
    end

    // Departure pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dep <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_dep <= w_depart;
            if (i_arr && !w_depart && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_q   = r_q;
    assign o_dep = r_dep;
    assign o_ovf = r_ovf;
endmodule

// Top: two independent streets plus the shared light-safety monitor.
module tl_traffic_model #(
    parameter int QW         = 4,
    parameter int DEPART_CYC = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          dep_a,
    output logic          dep_b,
    output logic          ovf_a,
    output logic          ovf_b,
    output logic          conflict
);
    localparam logic [1:0] L_RED     = 2'b10;
    localparam logic [1:0] L_ILLEGAL = 2'b11;

    logic w_unsafe;
    logic r_conflict;

    tl_traffic_street #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_street_a (
        .clk     (clk),
        .reset_n (reset_n),
        .i_arr   (arr_a),
        .i_light (La),
        .o_q     (qa),
        .o_dep   (dep_a),
        .o_ovf   (ovf_a)
    );

    tl_traffic_street #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_street_b (
        .clk     (clk),
        .reset_n (reset_n),
        .i_arr   (arr_b),
        .i_light (Lb),
        .o_q     (qb),
        .o_dep   (dep_b),
        .o_ovf   (ovf_b)
    );

    // Unsafe: neither street held at red (both yellow included), or any
    // illegal code on either street.
    assign w_unsafe = ((La != L_RED) && (Lb != L_RED)) ||
                      (La == L_ILLEGAL) || (Lb == L_ILLEGAL);

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict <= 1'b0;
        end else if (w_unsafe) begin
            r_conflict <= 1'b1;
        end
    end

    assign conflict = r_conflict;
    // Occupancy sensors follow the registered counts directly.
    assign Ta = (qa != '0);
    assign Tb = (qb != '0);
endmodule

// File: tb/tb_tl_traffic_model.sv
// Bench for tl_traffic_model: a cycle model predicts every output after each
// edge; predictions are queued when stimulus is driven and compared after
// the edge.
module tb_tl_traffic_model;
  localparam int QW   = 4;
  localparam int DEP  = 2;
  localparam int QMAX = (1 << QW) - 1;
  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] X = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  initial forever #5 clk = ~clk;

  logic          arr_a, arr_b;
  logic [1:0]    la, lb;
  logic          ta, tb;
  logic [QW-1:0] qa, qb;
  logic          dep_a, dep_b, ovf_a, ovf_b, conflict;

  tl_traffic_model #(.QW(QW), .DEPART_CYC(DEP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .arr_a    (arr_a),
    .arr_b    (arr_b),
    .La       (la),
    .Lb       (lb),
    .Ta       (ta),
    .Tb       (tb),
    .qa       (qa),
    .qb       (qb),
    .dep_a    (dep_a),
    .dep_b    (dep_b),
    .ovf_a    (ovf_a),
    .ovf_b    (ovf_b),
    .conflict (conflict)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [14:0] exp_q[$];

  int   m_qa, m_qb, m_ta, m_tb;
  logic m_depa, m_depb, m_ovfa, m_ovfb, m_conf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_qa = 0; m_qb = 0; m_ta = 0; m_tb = 0;
    m_depa = 0; m_depb = 0; m_ovfa = 0; m_ovfb = 0; m_conf = 0;
  endtask

  // One street for one edge, from the behavioural description.
  task automatic street(input logic arr, input logic [1:0] l, input int q_in, input int t_in,
                        input logic ovf_in, output int q_out, output int t_out,
                        output logic dep_out, output logic ovf_out);
    logic green, go;
    green   = (l == G);
    go      = green && (q_in > 0) && (t_in == DEP - 1);
    dep_out = go;
    ovf_out = ovf_in;
    q_out   = q_in;
    t_out   = (green && q_in > 0 && !go) ? t_in + 1 : 0;
    if (arr && !go) begin
      if (q_in < QMAX) q_out = q_in + 1;
      else ovf_out = 1'b1;
    end else if (!arr && go) begin
      q_out = q_in - 1;
    end
  endtask

  function automatic logic [14:0] model_pack();
    return {m_qa != 0, m_qb != 0, 4'(m_qa), 4'(m_qb), m_depa, m_depb, m_ovfa, m_ovfb, m_conf};
  endfunction

  task automatic compare_outputs(input string ph);
    logic [14:0] e;
    e = exp_q.pop_front();
    check({ph, ":Ta"},       ta,       e[14]);
    check({ph, ":Tb"},       tb,       e[13]);
    check({ph, ":qa"},       qa,       e[12:9]);
    check({ph, ":qb"},       qb,       e[8:5]);
    check({ph, ":dep_a"},    dep_a,    e[4]);
    check({ph, ":dep_b"},    dep_b,    e[3]);
    check({ph, ":ovf_a"},    ovf_a,    e[2]);
    check({ph, ":ovf_b"},    ovf_b,    e[1]);
    check({ph, ":conflict"}, conflict, e[0]);
  endtask

  // driver: called at posedge+1, drives inputs for the next edge
  task automatic step(input string ph, input logic aa, input logic ab,
                      input logic [1:0] a_l, input logic [1:0] b_l);
    arr_a = aa; arr_b = ab; la = a_l; lb = b_l;
    if (!reset_n) begin
      model_reset();
    end else begin
      street(aa, a_l, m_qa, m_ta, m_ovfa, m_qa, m_ta, m_depa, m_ovfa);
      street(ab, b_l, m_qb, m_tb, m_ovfb, m_qb, m_tb, m_depb, m_ovfb);
      if (((a_l != R) && (b_l != R)) || (a_l == X) || (b_l == X)) m_conf = 1'b1;
    end
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    compare_outputs(ph);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step("rst", 1'b0, 1'b0, R, R);
    step("rst", 1'b0, 1'b0, R, R);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] pick_a [6];
    logic [1:0] pick_b [6];
    reset_n = 1'b0;
    arr_a = 1'b0; arr_b = 1'b0; la = R; lb = R;
    model_reset();
    @(posedge clk);
    #1;

    // 1: held in reset with activity and both green, then release
    for (int i = 0; i < 4; i++) step("in_reset", i[0], ~i[0], G, G);
    reset_n = 1'b1;
    step("release", 1'b0, 1'b0, R, R);

    // 2: three arrivals on A under red
    for (int i = 0; i < 3; i++) step("arrive_a", 1'b1, 1'b0, R, R);
    check("qa_after_3", qa, 3);
    check("tb_idle", tb, 0);

    // 3: six cycles of green drain three cars, then green-1-then-yellow
    for (int i = 0; i < 6; i++) step("drain_a", 1'b0, 1'b0, G, R);
    check("qa_drained", qa, 0);
    step("refill_a", 1'b1, 1'b0, R, R);
    step("refill_a", 1'b1, 1'b0, R, R);
    step("short_green", 1'b0, 1'b0, G, R);
    step("yellow", 1'b0, 1'b0, Y, R);
    step("yellow", 1'b0, 1'b0, Y, R);
    check("qa_kept", qa, 2);

    // 4: fill B, overflow, then green with arrivals held high
    for (int i = 0; i < QMAX; i++) step("fill_b", 1'b0, 1'b1, R, R);
    step("over_b", 1'b0, 1'b1, R, R);
    check("ovf_b_set", ovf_b, 1);
    for (int i = 0; i < 6; i++) step("full_green_b", 1'b0, 1'b1, R, G);
    check("qb_full", qb, QMAX);

    // 5: conflict, sticky; then illegal code alone after a fresh reset
    step("conflict", 1'b0, 1'b0, G, Y);
    step("sticky", 1'b0, 1'b0, R, R);
    step("sticky", 1'b0, 1'b0, R, R);
    do_reset();
    step("illegal_a", 1'b0, 1'b0, X, R);
    check("conflict_illegal", conflict, 1);

    // 6: asynchronous reset with a crossing in progress
    do_reset();
    for (int i = 0; i < 5; i++) step("load_a", 1'b1, 1'b0, R, R);
    step("partial", 1'b0, 1'b0, G, R);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_qa", qa, 0);
    check("async_Ta", ta, 0);
    check("async_dep", dep_a, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("after_rst", 1'b0, 1'b0, G, R);
    step("after_rst", 1'b0, 1'b0, G, R);

    // random traffic, mostly safe light pairs
    pick_a[0] = R; pick_b[0] = R;
    pick_a[1] = G; pick_b[1] = R;
    pick_a[2] = Y; pick_b[2] = R;
    pick_a[3] = R; pick_b[3] = G;
    pick_a[4] = R; pick_b[4] = Y;
    pick_a[5] = G; pick_b[5] = G;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int k;
      k = (i < 250) ? $urandom_range(0, 4) : $urandom_range(0, 5);
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_a[k], pick_b[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
